// File: rtl/switch_conditioner_if.sv
// Switch conditioner bus: groups the raw switch inputs, the software clear
// requests and the conditioned outputs that feed the data memory switch port.
//   sw_raw     : asynchronous raw switch levels from the pins
//   clr_events : per-bit clear request for the sticky change flags
//   switches   : debounced stable levels
//   sw_changed : one-cycle pulse per bit whose stable level just changed
//   sw_event   : sticky per-bit change flag
//   any_event  : OR of sw_event
interface switch_conditioner_if #(
    parameter int unsigned N = 10
);
    logic [N-1:0] sw_raw;
    logic [N-1:0] clr_events;
    logic [N-1:0] switches;
    logic [N-1:0] sw_changed;
    logic [N-1:0] sw_event;
    logic         any_event;

    // Board / software side: drives pins and clears, observes conditioned state.
    modport master (
        output sw_raw,
        output clr_events,
        input  switches,
        input  sw_changed,
        input  sw_event,
        input  any_event
    );

    // Conditioner side.
    modport slave (
        input  sw_raw,
        input  clr_events,
        output switches,
        output sw_changed,
        output sw_event,
        output any_event
    );
endinterface

// File: rtl/switch_conditioner.sv
// Slide-switch input conditioner. Each raw line is brought into the clock
// domain through a two-flop synchroniser and then debounced independently:
// a new synchronised level must persist for DEBOUNCE_CYCLES consecutive cycles
// before it is accepted into the stable output. Accepts produce a registered
// one-cycle pulse and set a sticky flag that software clears per bit.
//   clk   : processor clock, rising edge
//   reset : synchronous, active-high
//   bus   : switch_conditioner_if slave (sw_raw, clr_events in;
//           switches, sw_changed, sw_event, any_event out)
module switch_conditioner #(
    parameter int unsigned N               = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input logic                 clk,
    input logic                 reset,
    switch_conditioner_if.slave bus
);
    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CntLast  = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {StStable, StPending} state_e;

    logic [N-1:0] sync1_q;
    logic [N-1:0] s_q;
    logic [N-1:0] switches_q;
    logic [N-1:0] switches_d;
    logic [N-1:0] sw_changed_q;
    logic [N-1:0] sw_event_q;
    logic [N-1:0] accept;

    for (genvar i = 0; i < N; i++) begin : g_bit
        state_e        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          acc;

        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= StStable;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            acc     = 1'b0;
            unique case (state_q)
                StStable: begin
                    if (s_q[i] != switches_q[i]) begin
                        // A one-cycle debounce has nothing to wait for.
                        if (DEBOUNCE_CYCLES == 1) begin
                            acc = 1'b1;
                        end else begin
                            state_d = StPending;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                StPending: begin
                    if (s_q[i] == switches_q[i]) begin
                        // Glitch ended before it was accepted.
                        state_d = StStable;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        acc     = 1'b1;
                        state_d = StStable;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = StStable;
                    cnt_d   = '0;
                end
            endcase
        end

        assign accept[i] = acc;
    end

    // An accept always means s differs from switches, so take s on accept.
    assign switches_d = (accept & s_q) | (~accept & switches_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q      <= '0;
            s_q          <= '0;
            switches_q   <= '0;
            sw_changed_q <= '0;
            sw_event_q   <= '0;
        end else begin
            sync1_q      <= bus.sw_raw;
            s_q          <= sync1_q;
            switches_q   <= switches_d;
            sw_changed_q <= accept;
            // Set wins over a clear on the same edge so no change is lost.
            sw_event_q   <= accept | (sw_event_q & ~bus.clr_events);
        end
    end

    assign bus.switches   = switches_q;
    assign bus.sw_changed = sw_changed_q;
    assign bus.sw_event   = sw_event_q;
    assign bus.any_event  = |sw_event_q;
endmodule
